// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port SRAM.
// Optionally zero-fills the SRAM after reset before accepting requests.
module sram_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  req_a_valid,
  output logic                  req_a_ready,
  input  logic                  req_a_we,
  input  logic [ADDR_WIDTH-1:0] req_a_addr,
  input  logic [DATA_WIDTH-1:0] req_a_wdata,
  input  logic                  req_b_valid,
  output logic                  req_b_ready,
  input  logic                  req_b_we,
  input  logic [ADDR_WIDTH-1:0] req_b_addr,
  input  logic [DATA_WIDTH-1:0] req_b_wdata,
  output logic                  rsp_a_valid,
  output logic [DATA_WIDTH-1:0] rsp_a_rdata,
  output logic                  rsp_b_valid,
  output logic [DATA_WIDTH-1:0] rsp_b_rdata,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  init_done
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  last_b_q, last_b_d;
  logic                  rsp_a_q, rsp_a_d;
  logic                  rsp_b_q, rsp_b_d;
  logic                  grant_a, grant_b;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_b_d  = last_b_q;
    rsp_a_d   = 1'b0;
    rsp_b_d   = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    mem_csb0  = 1'b1;
    mem_web0  = 1'b1;
    mem_addr0 = '0;
    mem_din0  = '0;
    if (!rst) begin
      unique case (state_q)
        INIT: begin
          mem_csb0  = 1'b0;
          mem_web0  = 1'b0;
          mem_addr0 = clr_cnt_q;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) state_d = RUN;
        end
        RUN: begin
          // On contention, the side that did not win last goes first
          grant_a = req_a_valid && (!req_b_valid || last_b_q);
          grant_b = req_b_valid && (!req_a_valid || !last_b_q);
          if (grant_a) begin
            mem_csb0  = 1'b0;
            mem_web0  = !req_a_we;
            mem_addr0 = req_a_addr;
            mem_din0  = req_a_wdata;
            last_b_d  = 1'b0;
            rsp_a_d   = !req_a_we;
          end else if (grant_b) begin
            mem_csb0  = 1'b0;
            mem_web0  = !req_b_we;
            mem_addr0 = req_b_addr;
            mem_din0  = req_b_wdata;
            last_b_d  = 1'b1;
            rsp_b_d   = !req_b_we;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      last_b_q  <= 1'b1;
      rsp_a_q   <= 1'b0;
      rsp_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_b_q  <= last_b_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
    end
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;
  assign rsp_a_valid = rsp_a_q;
  assign rsp_b_valid = rsp_b_q;
  assign rsp_a_rdata = mem_dout0;
  assign rsp_b_rdata = mem_dout0;
  assign init_done   = !rst && (state_q == RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, reference model, directed
// scenarios and randomized traffic.
module tb_sram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic rst, va, vb, wea, web_i;
  logic [AW-1:0] aa, ab;
  logic [DW-1:0] wda, wdb;
  logic ra, rb, rsva, rsvb, csb, web, idone;
  logic [DW-1:0] rda, rdb, mdin, mdout;
  logic [AW-1:0] maddr;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk0(clk0), .rst(rst),
    .req_a_valid(va), .req_a_ready(ra), .req_a_we(wea),
    .req_a_addr(aa), .req_a_wdata(wda),
    .req_b_valid(vb), .req_b_ready(rb), .req_b_we(web_i),
    .req_b_addr(ab), .req_b_wdata(wdb),
    .rsp_a_valid(rsva), .rsp_a_rdata(rda),
    .rsp_b_valid(rsvb), .rsp_b_rdata(rdb),
    .mem_csb0(csb), .mem_web0(web), .mem_addr0(maddr),
    .mem_din0(mdin), .mem_dout0(mdout), .init_done(idone)
  );

  logic rst1, va1, ra1, rb1, rsva1, rsvb1, csb1, web1, idone1;
  logic [DW-1:0] rda1, rdb1, mdin1;
  logic [DW-1:0] mdout1 = '0;
  logic [AW-1:0] maddr1;
  logic [AW-1:0] zaddr = '0;
  logic [DW-1:0] zdata = '0;
  logic zbit = 1'b0;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) dut1 (
    .clk0(clk0), .rst(rst1),
    .req_a_valid(va1), .req_a_ready(ra1), .req_a_we(zbit),
    .req_a_addr(zaddr), .req_a_wdata(zdata),
    .req_b_valid(zbit), .req_b_ready(rb1), .req_b_we(zbit),
    .req_b_addr(zaddr), .req_b_wdata(zdata),
    .rsp_a_valid(rsva1), .rsp_a_rdata(rda1),
    .rsp_b_valid(rsvb1), .rsp_b_rdata(rdb1),
    .mem_csb0(csb1), .mem_web0(web1), .mem_addr0(maddr1),
    .mem_din0(mdin1), .mem_dout0(mdout1), .init_done(idone1)
  );

  logic [DW-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;

  always @(posedge clk0) begin
    if (!csb) begin
      if (!web) sram[maddr] <= mdin;
      else      mdout <= sram[maddr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference model: state as plain integers and an array of expected contents
  logic [DW-1:0] ref_mem [DEPTH];
  bit m_init = 1'b1;
  int m_cnt = 0;
  int m_last = 1;
  bit m_rspa = 1'b0, m_rspb = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int init_wr_cnt = 0;

  always @(negedge clk0) begin
    int win;
    if (rst) begin
      chk("rst_csb", csb, 1); chk("rst_web", web, 1);
      chk("rst_addr", maddr, 0); chk("rst_din", mdin, 0);
      chk("rst_ready", {ra, rb}, 0); chk("rst_rsp", {rsva, rsvb}, 0);
      chk("rst_done", idone, 0);
      m_init = 1'b1; m_cnt = 0; m_last = 1;
      m_rspa = 1'b0; m_rspb = 1'b0; init_wr_cnt = 0;
    end else if (m_init) begin
      chk("init_csb", csb, 0); chk("init_web", web, 0);
      chk("init_addr", maddr, m_cnt); chk("init_din", mdin, 0);
      chk("init_ready", {ra, rb}, 0); chk("init_rsp", {rsva, rsvb}, 0);
      chk("init_done_lo", idone, 0);
      if (!csb && !web && mdin == 0) init_wr_cnt++;
      ref_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_init = 1'b0;
    end else begin
      if (va && vb) win = (m_last == 0) ? 1 : 0;
      else if (va) win = 0;
      else if (vb) win = 1;
      else win = -1;
      chk("ready_a", ra, win == 0); chk("ready_b", rb, win == 1);
      chk("rsp_a", rsva, m_rspa); chk("rsp_b", rsvb, m_rspb);
      if (m_rspa) chk("rdata_a", rda, m_rdata);
      if (m_rspb) chk("rdata_b", rdb, m_rdata);
      chk("run_done", idone, 1);
      m_rspa = 1'b0; m_rspb = 1'b0;
      if (win < 0) begin
        chk("idle_csb", csb, 1); chk("idle_web", web, 1);
        chk("idle_addr", maddr, 0); chk("idle_din", mdin, 0);
      end else begin
        bit we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        we = (win == 0) ? wea : web_i;
        ad = (win == 0) ? aa : ab;
        wd = (win == 0) ? wda : wdb;
        chk("g_csb", csb, 0); chk("g_web", web, !we);
        chk("g_addr", maddr, ad); chk("g_din", mdin, wd);
        m_last = win;
        if (we) ref_mem[ad] = wd;
        else begin
          m_rdata = ref_mem[ad];
          if (win == 0) m_rspa = 1'b1; else m_rspb = 1'b1;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk0);
    #1;
  endtask

  task automatic wait_init(input string n);
    for (int i = 0; i < 300 && !idone; i++) step();
    chk(n, idone, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    bit pa, pb;
    rst = 1'b1; rst1 = 1'b1; va1 = 1'b1;
    va = 0; vb = 0; wea = 0; web_i = 0;
    aa = '0; ab = '0; wda = '0; wdb = '0;
    repeat (3) step();
    chk("d1_rst_done", idone1, 0);
    chk("d1_rst_ready", ra1, 0);
    rst = 1'b0; rst1 = 1'b0;
    #1;
    chk("d1_done_first", idone1, 1);
    chk("d1_grant_first", ra1, 1);
    wait_init("init_timeout");
    chk("init_writes", init_wr_cnt, 128);

    va = 1; vb = 1; s = "";
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("one_hot", ra && rb, 0);
      s = {s, ra ? "A" : (rb ? "B" : "-")};
      step();
    end
    chk("alternate", (s == "ABABAB"), 1);

    va = 0; s = "";
    for (int i = 0; i < 4; i++) begin
      #1;
      s = {s, rb ? "B" : "-"};
      step();
    end
    chk("b_only", (s == "BBBB"), 1);
    va = 1;
    #1;
    chk("a_after_b", {ra, rb}, 2'b10);
    step();
    va = 0; vb = 0;
    step();

    va = 1; wea = 1; aa = 7'h05; wda = 32'hDEADBEEF;
    #1 chk("wr_grant", ra, 1);
    step();
    wea = 0;
    step();
    va = 0;
    #1;
    chk("rd_valid", rsva, 1);
    chk("rd_data", rda, 32'hDEADBEEF);
    chk("rd_b_quiet", rsvb, 0);
    step();
    chk("rd_pulse_end", rsva, 0);

    va = 1; wea = 0; aa = 7'h7F;
    step();
    va = 0;
    #1;
    chk("rd7f_valid", rsva, 1);
    chk("rd7f_data", rda, 0);
    rst = 1'b1;
    #1 chk("rst_drop", rsva, 0);
    step(); step();
    rst = 1'b0;
    @(negedge clk0);
    chk("restart_addr", maddr, 0);
    chk("restart_csb", csb, 0);
    step();
    wait_init("reinit_timeout");

    pa = 0; pb = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pa) begin
        va = $urandom_range(0, 1); wea = $urandom_range(0, 1);
        aa = AW'($urandom_range(0, 15)); wda = $urandom;
      end
      if (!pb) begin
        vb = $urandom_range(0, 1); web_i = $urandom_range(0, 1);
        ab = AW'($urandom_range(0, 15)); wdb = $urandom;
      end
      #1;
      pa = va && !ra;
      pb = vb && !rb;
      step();
    end
    va = 0; vb = 0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
